sys_arr_out_deskew: RTL and testbench
=====================================

Name: sys_arr_out_deskew

Overview:
- Receiving end of the weight-stationary sys_arr result interface.
- The array emits results diagonally skewed: column j of output row r appears one cycle after column j-1.
- This block removes the skew and emits one fully aligned output row per cycle, with a valid strobe, row index and completion pulse.
- Sits between sys_arr final_result_out and the output buffer / writeback path.

Parameters:
- PE_OUT_WIDTH, 32, width of one column result (two's complement).
- SYS_ARR_SIZE, 8, number of array columns (lanes).
- ARR_LATENCY, 10, cycles from the start sample to column-0 row-0 result being valid on result_in.
- MAX_ROWS, 256, maximum output rows per tile.
- ROW_W, $clog2(MAX_ROWS+1), width of the row-count and row-index fields.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse; sampled in the same cycle the first skewed activation word enters sys_arr.
- num_rows  in  ROW_W  rows in the tile; latched when start is accepted.
- result_in  in  PE_OUT_WIDTH*SYS_ARR_SIZE  skewed results from sys_arr; column j occupies bits [PE_OUT_WIDTH*j +: PE_OUT_WIDTH].
- busy  out  1  high from an accepted start until done.
- out_valid  out  1  out_data holds an aligned row.
- out_row_idx  out  ROW_W  index of the row on out_data, 0-based.
- out_data  out  PE_OUT_WIDTH*SYS_ARR_SIZE  aligned row, same lane mapping as result_in.
- done  out  1  single-cycle pulse after the last row.

Behaviour:
- Reset values: all outputs 0, all delay-line stages 0, FSM in IDLE. Reset is asynchronous and may assert in any state; it aborts the tile immediately with no further out_valid or done.
- Timing reference: cycle T0 is the cycle in which start is sampled high in IDLE.
- Input arrival: column j of row r is valid on result_in at T0+ARR_LATENCY+r+j.
- Alignment: column j passes through a free-running delay line of SYS_ARR_SIZE-1-j register stages (column SYS_ARR_SIZE-1 has zero stages), then through a common output register.
- Output timing: row r is presented with out_valid=1 at cycle T0+ARR_LATENCY+SYS_ARR_SIZE+r. Rows are emitted on consecutive cycles with no gaps. There is no backpressure, because the array cannot stall.
- FSM states:
  - IDLE: start=1 with num_rows=0 leads to DONE. start=1 with num_rows>0 latches num_rows, clears the counter and leads to WAIT.
  - WAIT: counts ARR_LATENCY+SYS_ARR_SIZE-1 cycles, then goes to DRAIN.
  - DRAIN: out_valid=1; out_row_idx increments each cycle from 0. After row num_rows-1, goes to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- busy is 1 in WAIT and DRAIN.
- start while busy=1 is ignored. Callers must wait for done.
- start in the DONE cycle is accepted and treated as in IDLE: the FSM goes directly to WAIT or DONE, so back-to-back tiles are possible.
- num_rows > MAX_ROWS is clamped to MAX_ROWS.
- out_data and out_row_idx hold their last values when out_valid=0. Testbenches check them only while out_valid=1.
- No arithmetic on data except the optional ReLU; widths are preserved.
- Counter width: $clog2(ARR_LATENCY+SYS_ARR_SIZE+MAX_ROWS+1).

Optional Feature:
- Macro DESKEW_RELU_EN.
- Defined: each lane is forced to 0 when its MSB is 1, applied at the output register. Latency is unchanged.
- Undefined: lanes pass through bit-exact.

Decomposition:
- Shared package sys_arr_pkg holds:
  - PE_OUT_WIDTH and SYS_ARR_SIZE defaults;
  - the FSM state encoding (IDLE=0, WAIT=1, DRAIN=2, DONE=3);
  - a lane-slice helper constant for PE_OUT_WIDTH*j.
- One natural sub-module, deskew_delay_line, instantiated once per lane:
  - parameters WIDTH and DEPTH;
  - DEPTH=0 is a pass-through.

Test Plan:
- Nominal tile:
  - Stimulus: start at T0 with num_rows=8. The bench drives result_in skewed per the arrival formula. Row 0 is 191,172,131,140,172,120,106,117; row 7 is 202,226,198,151,238,150,119,156.
  - Response: out_valid at T0+18 through T0+25; row 0 and row 7 values exactly as driven; out_row_idx 0..7; done at T0+26; busy high T0+1..T0+25.
- Empty tile:
  - Stimulus: start with num_rows=0.
  - Response: done at T0+1, busy never high, no out_valid.
- Start while busy:
  - Stimulus: second start at T0+5 with num_rows=3.
  - Response: ignored; the original 8 rows are emitted, done at T0+26 only.
- Back-to-back tiles:
  - Stimulus: start=1 with num_rows=2 in the done cycle (T0+26).
  - Response: out_valid at T0+44..45, done at T0+46.
- Reset mid-drain:
  - Stimulus: reset asserted at T0+21 for 2 cycles.
  - Response: outputs 0 asynchronously, no done; a fresh 8-row tile afterwards produces correct rows.
- DESKEW_RELU_EN:
  - Stimulus: lane 3 of row 0 = 32'hFFFFFF85 (-123).
  - Response: with the macro, output lane 3 = 0; without it, 32'hFFFFFF85. Other lanes are unchanged in both builds.

Source files
------------

// File: rtl/sys_arr_pkg.sv
// Shared definitions for the sys_arr result path: default geometry, deskew FSM
// encoding and the lane-slice helper used to address one column of a packed row.
package sys_arr_pkg;

  localparam int DEF_PE_OUT_WIDTH = 32;
  localparam int DEF_SYS_ARR_SIZE = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } deskew_state_t;

  // LSB position of column `lane` inside a packed row of `width`-bit lanes.
  function automatic int lane_lsb(input int lane, input int width);
    return width * lane;
  endfunction

endpackage

// File: rtl/deskew_delay_line.sv
// Free-running fixed-depth delay line for one result column; DEPTH=0 is a
// plain wire so the last column needs no special casing in the top level.
module deskew_delay_line #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk_reset;
      assign unused_clk_reset = clk | reset;
      assign dout = din;
    end else begin : g_regs
      logic [WIDTH-1:0] stage [DEPTH];

      // NOTE: this shift register is reset on purpose: stale lane data must never
      // appear on the output register after an aborted tile, so it is not left as RAM.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/sys_arr_out_deskew.sv
// Removes the diagonal column skew of sys_arr results and emits one aligned row
// per cycle. Optional macro DESKEW_RELU_EN clamps negative lanes to zero at the output register.
module sys_arr_out_deskew
  import sys_arr_pkg::*;
#(
  parameter int PE_OUT_WIDTH = DEF_PE_OUT_WIDTH,
  parameter int SYS_ARR_SIZE = DEF_SYS_ARR_SIZE,
  parameter int ARR_LATENCY  = 10,
  parameter int MAX_ROWS     = 256,
  parameter int ROW_W        = $clog2(MAX_ROWS + 1)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [ROW_W-1:0]                     num_rows,
  input  logic [PE_OUT_WIDTH*SYS_ARR_SIZE-1:0] result_in,
  output logic                                 busy,
  output logic                                 out_valid,
  output logic [ROW_W-1:0]                     out_row_idx,
  output logic [PE_OUT_WIDTH*SYS_ARR_SIZE-1:0] out_data,
  output logic                                 done
);

  localparam int BUS_W = PE_OUT_WIDTH * SYS_ARR_SIZE;
  localparam int CNT_W = $clog2(ARR_LATENCY + SYS_ARR_SIZE + MAX_ROWS + 1);
  // Last WAIT count: the cycle in which row 0 is aligned at the delay-line outputs.
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(ARR_LATENCY + SYS_ARR_SIZE - 2);
  localparam logic [ROW_W-1:0] MAX_ROWS_V = ROW_W'(MAX_ROWS);

  deskew_state_t    state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic [ROW_W-1:0] rows_q;
  logic [ROW_W-1:0] row_idx;
  logic [BUS_W-1:0] aligned;
  logic [BUS_W-1:0] shaped;
  logic [BUS_W-1:0] data_q;
  logic             accept;
  logic             last_row;

  assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_row = (row_idx == rows_q - ROW_W'(1));

  // Column j arrives j cycles after column 0, so it is delayed by the remaining lanes.
  generate
    for (genvar j = 0; j < SYS_ARR_SIZE; j++) begin : g_lane
      deskew_delay_line #(
        .WIDTH (PE_OUT_WIDTH),
        .DEPTH (SYS_ARR_SIZE - 1 - j)
      ) u_delay (
        .clk   (clk),
        .reset (reset),
        .din   (result_in[lane_lsb(j, PE_OUT_WIDTH) +: PE_OUT_WIDTH]),
        .dout  (aligned[lane_lsb(j, PE_OUT_WIDTH) +: PE_OUT_WIDTH])
      );
    end
  endgenerate

`ifdef DESKEW_RELU_EN
  always_comb begin
    shaped = aligned;
    for (int j = 0; j < SYS_ARR_SIZE; j++) begin
      if (aligned[lane_lsb(j, PE_OUT_WIDTH) + PE_OUT_WIDTH - 1])
        shaped[lane_lsb(j, PE_OUT_WIDTH) +: PE_OUT_WIDTH] = '0;
    end
  end
`else
  assign shaped = aligned;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // NOTE: every combinational output gets a default before the case, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) state_next = (num_rows == '0) ? ST_DONE : ST_WAIT;
        else       state_next = ST_IDLE;
      end
      ST_WAIT:  if (wait_cnt == WAIT_LAST) state_next = ST_DRAIN;
      ST_DRAIN: if (last_row)              state_next = ST_DONE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_WAIT:  busy = 1'b1;
      ST_DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  // Output register loads only for rows being presented, so it holds between tiles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      rows_q   <= '0;
      row_idx  <= '0;
      data_q   <= '0;
    end else begin
      if (accept) begin
        wait_cnt <= '0;
        if (num_rows != '0) rows_q <= (num_rows > MAX_ROWS_V) ? MAX_ROWS_V : num_rows;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end

      if (state_next == ST_DRAIN) begin
        row_idx <= (state == ST_DRAIN) ? row_idx + ROW_W'(1) : '0;
        data_q  <= shaped;
      end
    end
  end

  assign out_row_idx = row_idx;
  assign out_data    = data_q;

endmodule

// File: tb/tb_sys_arr_out_deskew.sv
// Scoreboard bench for sys_arr_out_deskew: directed tiles push expected rows and
// done pulses into queues; a negedge monitor pops and compares them against the DUT.
module tb_sys_arr_out_deskew;

  localparam int W   = 32;
  localparam int N   = 8;
  localparam int RW  = 9;
  localparam int LAT = 10;
  localparam int MAXR = 256;

  typedef struct {
    int               cyc;
    logic [RW-1:0]    idx;
    logic [W*N-1:0]   data;
  } exp_row_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [RW-1:0]  num_rows = '0;
  logic [W*N-1:0] result_in = '0;
  logic           busy, out_valid, done;
  logic [RW-1:0]  out_row_idx;
  logic [W*N-1:0] out_data;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  exp_row_t exp_q [$];
  int       done_q [$];

  int tile_t0 = 0;
  int tile_rows = 0;
  int tile_id = 0;
  bit tile_active = 1'b0;

  int row0_v [N] = '{191, 172, 131, 140, 172, 120, 106, 117};
  int row7_v [N] = '{202, 226, 198, 151, 238, 150, 119, 156};

  sys_arr_out_deskew dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_rows    (num_rows),
    .result_in   (result_in),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_row_idx (out_row_idx),
    .out_data    (out_data),
    .done        (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W*N-1:0] act, input logic [W*N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] gen(input int id, input int r, input int j);
    if (id == 0 && r == 0) return W'(row0_v[j]);
    if (id == 0 && r == 7) return W'(row7_v[j]);
    if (id == 2 && r == 0 && j == 3) return 32'hFFFF_FF85;
    if (id == 2 && r == 1 && j == 5) return 32'h8000_0000;
    return W'(id * 65536 + r * 256 + j * 16 + 7);
  endfunction

  function automatic logic [W*N-1:0] row_exp(input int id, input int r);
    logic [W*N-1:0] v;
    logic [W-1:0]   lane;
    v = '0;
    for (int j = 0; j < N; j++) begin
      lane = gen(id, r, j);
`ifdef DESKEW_RELU_EN
      if (lane[W-1]) lane = '0;
`endif
      v[j*W +: W] = lane;
    end
    return v;
  endfunction

  // Skewed source: column j of row r is presented during cycle t0+LAT+r+j.
  always @(negedge clk) begin : drive_src
    logic [W*N-1:0] v;
    int r;
    for (int j = 0; j < N; j++) begin
      r = cyc - tile_t0 - LAT - j;
      if (tile_active && r >= 0 && r < tile_rows) v[j*W +: W] = gen(tile_id, r, j);
      else                                        v[j*W +: W] = 32'hBAD0_0000 + W'(j);
    end
    result_in = v;
  end

  always @(negedge clk) begin : monitor
    exp_row_t e;
    int       dc;
    if (!reset) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_row", W*N'(out_valid), '0);
        end else begin
          e = exp_q.pop_front();
          check("row_cycle", W*N'(cyc), W*N'(e.cyc));
          check("row_idx", W*N'(out_row_idx), W*N'(e.idx));
          check("row_data", out_data, e.data);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        check("missed_row", W*N'(out_valid), W*N'(1));
      end

      if (done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", W*N'(done), '0);
        end else begin
          dc = done_q.pop_front();
          check("done_cycle", W*N'(cyc), W*N'(dc));
        end
      end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
        dc = done_q.pop_front();
        check("missed_done", W*N'(done), W*N'(1));
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Drives a one-cycle start pulse from the current negedge; expectations are
  // queued only for starts the DUT is supposed to accept.
  task automatic issue(input int n, input int id, input bit accepted);
    int eff;
    exp_row_t e;
    eff = (n > MAXR) ? MAXR : n;
    start    = 1'b1;
    num_rows = RW'(n);
    if (accepted) begin
      tile_t0     = cyc;
      tile_rows   = eff;
      tile_id     = id;
      tile_active = 1'b1;
      for (int r = 0; r < eff; r++) begin
        e.cyc  = cyc + LAT + N + r;
        e.idx  = RW'(r);
        e.data = row_exp(id, r);
        exp_q.push_back(e);
      end
      done_q.push_back((eff == 0) ? cyc + 1 : cyc + LAT + N + eff);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin : stimulus
    int t0;
    #1;
    check("rst_busy", W*N'(busy), '0);
    check("rst_valid", W*N'(out_valid), '0);
    check("rst_done", W*N'(done), '0);
    check("rst_idx", W*N'(out_row_idx), '0);
    check("rst_data", out_data, '0);
    wait_until(3);
    reset = 1'b0;

    // Nominal 8-row tile, an ignored start while busy, then a back-to-back tile.
    wait_until(5);
    t0 = cyc;
    check("idle_busy", W*N'(busy), '0);
    issue(8, 0, 1'b1);
    check("busy_t1", W*N'(busy), W*N'(1));
    wait_until(t0 + 5);
    issue(3, 9, 1'b0);
    wait_until(t0 + 17);
    check("busy_wait_end", W*N'(busy), W*N'(1));
    check("no_valid_wait", W*N'(out_valid), '0);
    wait_until(t0 + 25);
    check("busy_t25", W*N'(busy), W*N'(1));
    wait_until(t0 + 26);
    check("done_t26", W*N'(done), W*N'(1));
    check("busy_t26", W*N'(busy), '0);
    issue(2, 1, 1'b1);

    // Empty tile: immediate done, never busy.
    wait_until(t0 + 55);
    t0 = cyc;
    issue(0, 8, 1'b1);
    check("empty_done", W*N'(done), W*N'(1));
    check("empty_busy", W*N'(busy), '0);

    // Negative lanes (ReLU behaviour depends on the build).
    wait_until(t0 + 5);
    issue(2, 2, 1'b1);

    // num_rows above MAX_ROWS is clamped.
    wait_until(cyc + 25);
    issue(300, 5, 1'b1);
    wait_until(tile_t0 + LAT + N + MAXR + 4);

    // Asynchronous reset in the middle of a drain.
    t0 = cyc;
    issue(8, 3, 1'b1);
    wait_until(t0 + 21);
    #2;
    reset = 1'b1;
    exp_q.delete();
    done_q.delete();
    #1;
    check("abort_valid", W*N'(out_valid), '0);
    check("abort_busy", W*N'(busy), '0);
    check("abort_done", W*N'(done), '0);
    check("abort_data", out_data, '0);
    check("abort_idx", W*N'(out_row_idx), '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    wait_until(cyc + 4);
    t0 = cyc;
    issue(8, 4, 1'b1);
    wait_until(t0 + LAT + N + 8 + 6);
    check("rows_pending", W*N'(exp_q.size()), '0);
    check("done_pending", W*N'(done_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
